// File: rtl/dot_pkg.sv
// Shared types and constants for the sequential dot-product engine.
// Saturation limits are used only when DOT_SATURATE_EN is defined.
package dot_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_OUTPUT
  } dot_state_t;

  localparam int DOT_DATA_W = 8;
  localparam int DOT_ACC_W  = 16;

  function automatic logic signed [63:0] dot_sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] dot_sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic int dot_clog2w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dot_product_seq_if.sv
// Operand-read and result handshake bundle of dot_product_seq.
// master = sequencer side, slave = operand memory / result consumer.
interface dot_product_seq_if
  import dot_pkg::*;
#(
  parameter int NUM_VECTORS   = 3,
  parameter int VECTOR_LENGTH = 4,
  parameter int DATA_W        = DOT_DATA_W,
  parameter int ACC_W         = DOT_ACC_W
) ();

  localparam int VW = dot_clog2w(NUM_VECTORS);
  localparam int IW = dot_clog2w(VECTOR_LENGTH);

  logic                     rd_en;
  logic [VW-1:0]            rd_vec;
  logic [IW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] a_data;
  logic signed [DATA_W-1:0] b_data;
  logic                     res_valid;
  logic                     res_ready;
  logic [VW-1:0]            res_vec;
  logic signed [ACC_W-1:0]  res_data;

  modport master (
    output rd_en, rd_vec, rd_idx,
    input  a_data, b_data,
    output res_valid, res_vec, res_data,
    input  res_ready
  );

  modport slave (
    input  rd_en, rd_vec, rd_idx,
    output a_data, b_data,
    input  res_valid, res_vec, res_data,
    output res_ready
  );

endinterface

// File: rtl/dot_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// DOT_SATURATE_EN: sticky clamp to the accumulator range instead of wrap.
module dot_mac
  import dot_pkg::*;
#(
  parameter int DATA_W = DOT_DATA_W,
  parameter int ACC_W  = DOT_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_d
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    addend;

  assign prod   = a * b;
  assign addend = ACC_W'(prod);

`ifdef DOT_SATURATE_EN
  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(dot_sat_hi(ACC_W));
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(dot_sat_lo(ACC_W));

  logic                  sat;
  logic                  sat_d;
  logic signed [ACC_W:0] sum;

  assign sum = $signed({acc[ACC_W-1], acc}) + $signed({addend[ACC_W-1], addend});

  always_comb begin
    acc_d = acc;
    sat_d = sat;
    if (clr) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (en && !sat) begin
      if (sum > HI) begin
        acc_d = HI[ACC_W-1:0];
        sat_d = 1'b1;
      end else if (sum < LO) begin
        acc_d = LO[ACC_W-1:0];
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat <= 1'b0;
    else     sat <= sat_d;
  end
`else
  always_comb begin
    acc_d = acc;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc + addend;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_d;
  end

endmodule

// File: rtl/dot_product_seq.sv
// Batch sequencer: NUM_VECTORS dot products through one shared MAC.
// Optional DOT_SATURATE_EN selects a saturating accumulator in dot_mac.
module dot_product_seq
  import dot_pkg::*;
#(
  parameter int NUM_VECTORS   = 3,
  parameter int VECTOR_LENGTH = 4,
  parameter int DATA_W        = DOT_DATA_W,
  parameter int ACC_W         = DOT_ACC_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  dot_product_seq_if.master bus
);

  localparam int VW = dot_clog2w(NUM_VECTORS);
  localparam int IW = dot_clog2w(VECTOR_LENGTH);
  localparam logic [VW-1:0] VLAST = VW'(NUM_VECTORS - 1);
  localparam logic [IW-1:0] ILAST = IW'(VECTOR_LENGTH - 1);

  dot_state_t              state;
  logic [VW-1:0]           vcnt;
  logic [IW-1:0]           icnt;
  logic                    rd_en;
  logic                    dvalid;
  logic                    res_valid;
  logic [VW-1:0]           res_vec;
  logic signed [ACC_W-1:0] res_data;
  logic signed [ACC_W-1:0] acc_d;
  logic                    accept;
  logic                    last_vec;
  logic                    mac_clr;

  assign accept   = (state == S_OUTPUT) && bus.res_ready;
  assign last_vec = (vcnt == VLAST);
  assign mac_clr  = ((state == S_IDLE) && start) || (accept && !last_vec);

  dot_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (dvalid),
    .a     (bus.a_data),
    .b     (bus.b_data),
    .acc_d (acc_d)
  );

  assign busy          = (state != S_IDLE);
  assign bus.rd_en     = rd_en;
  assign bus.rd_vec    = vcnt;
  assign bus.rd_idx    = icnt;
  assign bus.res_valid = res_valid;
  assign bus.res_vec   = res_vec;
  assign bus.res_data  = res_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      vcnt      <= '0;
      icnt      <= '0;
      rd_en     <= 1'b0;
      dvalid    <= 1'b0;
      res_valid <= 1'b0;
      res_vec   <= '0;
      res_data  <= '0;
      done      <= 1'b0;
    end else begin
      done   <= 1'b0;
      dvalid <= rd_en;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            vcnt  <= '0;
            icnt  <= '0;
            rd_en <= 1'b1;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (icnt == ILAST) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        S_DRAIN: begin
          // acc_d already includes the final product landing this edge
          res_valid <= 1'b1;
          res_vec   <= vcnt;
          res_data  <= acc_d;
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            if (last_vec) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              vcnt  <= vcnt + 1'b1;
              icnt  <= '0;
              rd_en <= 1'b1;
              state <= S_READ;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_seq.sv
// Randomised bench for dot_product_seq with a cycle-level behavioural model.
// Model tracks expected busy/done/reads/results from batch timing rules.
module tb_dot_product_seq;
  import dot_pkg::*;

  localparam int NV = 3;
  localparam int VL = 4;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  dot_product_seq_if #(
    .NUM_VECTORS(NV), .VECTOR_LENGTH(VL), .DATA_W(DW), .ACC_W(AW)
  ) bus ();

  dot_product_seq #(
    .NUM_VECTORS(NV), .VECTOR_LENGTH(VL), .DATA_W(DW), .ACC_W(AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  logic signed [DW-1:0] ma [NV][VL];
  logic signed [DW-1:0] mb [NV][VL];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_data <= ma[bus.rd_vec][bus.rd_idx];
      bus.b_data <= mb[bus.rd_vec][bus.rd_idx];
    end
  end

  function automatic longint ref_dot(input int v);
    longint s = 0;
    longint hi = (longint'(1) <<< (AW - 1)) - 1;
    longint lo = -(longint'(1) <<< (AW - 1));
    bit sat = 1'b0;
    logic signed [AW-1:0] w;
    for (int i = 0; i < VL; i++) begin
`ifdef DOT_SATURATE_EN
      if (!sat) begin
        s += longint'(ma[v][i]) * longint'(mb[v][i]);
        if (s > hi) begin s = hi; sat = 1'b1; end
        else if (s < lo) begin s = lo; sat = 1'b1; end
      end
`else
      s += longint'(ma[v][i]) * longint'(mb[v][i]);
`endif
    end
    w = AW'(s);
    return longint'(w);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit     m_act = 1'b0;
  bit     m_was;
  int     m_nv = 0;
  int     m_vstart = 0;
  int     m_done_cyc = -10;
  bit     e_valid;
  bit     e_rd;
  bit     prev_valid = 1'b0;
  int     n_done = 0;
  longint got_q[$];
  int     rise_q[$];

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_rd_vec", bus.rd_vec, 0);
      chk("rst_rd_idx", bus.rd_idx, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_vec", bus.res_vec, 0);
      chk("rst_res_data", bus.res_data, 0);
      m_act = 1'b0;
      m_done_cyc = -10;
      prev_valid = 1'b0;
    end else begin
      m_was   = m_act;
      e_valid = m_act && (cyc >= m_vstart + VL + 1);
      e_rd    = m_act && (cyc >= m_vstart) && (cyc < m_vstart + VL);
      chk("busy", busy, m_act);
      chk("done", done, cyc == m_done_cyc);
      chk("rd_en", bus.rd_en, e_rd);
      chk("res_valid", bus.res_valid, e_valid);
      if (e_rd) begin
        chk("rd_vec", bus.rd_vec, m_nv);
        chk("rd_idx", bus.rd_idx, cyc - m_vstart);
      end
      if (bus.res_valid && !prev_valid) rise_q.push_back(cyc);
      prev_valid = bus.res_valid;
      if (done) n_done++;
      if (e_valid) begin
        chk("res_vec", bus.res_vec, m_nv);
        chk("res_data", bus.res_data, ref_dot(m_nv));
        if (bus.res_ready) begin
          got_q.push_back(longint'(bus.res_data));
          if (m_nv == NV - 1) begin
            m_act = 1'b0;
            m_done_cyc = cyc + 1;
          end else begin
            m_nv++;
            m_vstart = cyc + 1;
          end
        end
      end
      if (!m_was && start) begin
        m_act = 1'b1;
        m_nv = 0;
        m_vstart = cyc + 1;
      end
    end
  end

  // mode 0: ready high, 1: random ready + stray start, 2: 5-cycle stall
  task automatic run_batch(input int mode, output int c0, output int lat);
    int lows = 0;
    bit seen = 1'b0;
    got_q.delete();
    rise_q.delete();
    start = 1'b1;
    c0 = cyc;
    lat = -1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        seen = 1'b1;
        lat = cyc - c0;
        break;
      end
      start = (mode == 1) && (k == 2);
      unique case (mode)
        0: bus.res_ready = 1'b1;
        1: bus.res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.res_valid && lows < 5) begin
            bus.res_ready = 1'b0;
            lows++;
          end else begin
            bus.res_ready = 1'b1;
          end
        end
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("batch_done_seen", seen, 1);
    chk("batch_results", got_q.size(), NV);
  endtask

  task automatic load_const(input int v, input int a, input int b);
    for (int i = 0; i < VL; i++) begin
      ma[v][i] = DW'(a);
      mb[v][i] = DW'(b);
    end
  endtask

  task automatic load_rand();
    for (int v = 0; v < NV; v++)
      for (int i = 0; i < VL; i++) begin
        ma[v][i] = DW'($urandom);
        mb[v][i] = DW'($urandom);
      end
  endtask

  int c0;
  int lat;
  int nb = 0;
  int nd_before;
  bit found;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.res_ready = 1'b0;
    for (int v = 0; v < NV; v++) load_const(v, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < VL; i++) begin
      ma[0][i] = DW'(i + 1);
      mb[0][i] = DW'(i + 5);
    end
    load_const(1, 1, -1);
    load_const(2, 0, 0);
    chk("pin_ref_70", ref_dot(0), 70);
    chk("pin_ref_m4", ref_dot(1), -4);
    run_batch(0, c0, lat);
    nb++;
    chk("first_res_seen", rise_q.size() > 0, 1);
    if (rise_q.size() > 0) chk("first_res_cycle", rise_q[0] - c0, VL + 2);
    chk("done_cycle", lat, NV * (VL + 2) + 1);
    if (got_q.size() == NV) begin
      chk("A_res0", got_q[0], 70);
      chk("A_res1", got_q[1], -4);
      chk("A_res2", got_q[2], 0);
    end

    // start in the done cycle chains a new batch
    load_const(0, -10, 10);
    chk("pin_ref_m400", ref_dot(0), -400);
    run_batch(2, c0, lat);
    nb++;
    chk("stall_done_cycle", lat, NV * (VL + 2) + 1 + 5);
    if (got_q.size() == NV) begin
      chk("B_res0", got_q[0], -400);
      chk("B_res1", got_q[1], -4);
      chk("B_res2", got_q[2], 0);
    end

    @(posedge clk); #1;
    load_const(0, -128, -128);
    run_batch(0, c0, lat);
    nb++;
`ifdef DOT_SATURATE_EN
    if (got_q.size() > 0) chk("m128_sat", got_q[0], 32767);
`else
    if (got_q.size() > 0) chk("m128_wrap", got_q[0], 0);
`endif

    // reset during READ of vector 1
    @(posedge clk); #1;
    for (int i = 0; i < VL; i++) begin
      ma[0][i] = DW'(i + 1);
      mb[0][i] = DW'(i + 5);
    end
    nd_before = n_done;
    found = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rd_en && bus.rd_vec == 1) begin
        found = 1'b1;
        break;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("reach_vec1_read", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_res_data", bus.res_data, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_done", n_done, nd_before);
    run_batch(0, c0, lat);
    nb++;
    if (got_q.size() > 0) chk("post_rst_res0", got_q[0], 70);

    for (int t = 0; t < 4; t++) begin
      repeat (2) @(posedge clk);
      #1;
      load_rand();
      run_batch(1, c0, lat);
      nb++;
    end

    repeat (4) @(posedge clk);
    #1;
    chk("done_pulses", n_done, nb);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
